// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame assembler: FSM states, error codes, default framing constants.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PAYLOAD  = 2'd1,
    CHECKSUM = 2'd2,
    HOLD     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_CHECKSUM = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_OVERRUN  = 2'b11
  } err_t;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE    = 8'hA5;
  localparam int unsigned DEFAULT_FRAME_LENGTH = 784;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, strobes terminal at LIMIT-1.
module frame_timeout_counter #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  assign terminal = enable && !clear && (count == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || terminal) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Hunts for a sync byte, writes FRAME_LENGTH pixels to RAM, verifies the checksum and holds the frame until acked.
// Optional inter-byte watchdog enabled by the FRAME_TIMEOUT_EN macro.
module uart_rx_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUMBER_OF_DATA_BITS = 8,
  parameter int unsigned FRAME_LENGTH        = DEFAULT_FRAME_LENGTH,
  parameter int unsigned ADDR_WIDTH          = 10,
  parameter logic [NUMBER_OF_DATA_BITS-1:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES      = 32'd1000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUMBER_OF_DATA_BITS-1:0] rx_data,
  input  logic                           rx_done_tick,
  output logic                           pixel_wr_en,
  output logic [ADDR_WIDTH-1:0]          pixel_wr_addr,
  output logic [NUMBER_OF_DATA_BITS-1:0] pixel_wr_data,
  output logic                           frame_valid,
  input  logic                           frame_ack,
  output logic                           frame_error_tick,
  output logic [1:0]                     error_code,
  output logic                           busy
);

  if (((64'd1 << ADDR_WIDTH) < 64'(FRAME_LENGTH)) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("uart_rx_frame_assembler: ADDR_WIDTH too small for FRAME_LENGTH or TIMEOUT_CYCLES < 2");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LENGTH - 1);

  state_t                         state;
  logic [ADDR_WIDTH-1:0]          byte_cnt;
  logic [NUMBER_OF_DATA_BITS-1:0] sum;
  logic [NUMBER_OF_DATA_BITS-1:0] sum_next;
  logic                           timeout;

  assign sum_next = sum + rx_data;

`ifdef FRAME_TIMEOUT_EN
  logic in_frame;
  assign in_frame = (state == PAYLOAD) || (state == CHECKSUM);

  // Held in clear outside a frame so every frame starts with a fresh budget.
  frame_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_done_tick || !in_frame),
    .enable  (in_frame),
    .terminal(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= HUNT;
      byte_cnt         <= '0;
      sum              <= '0;
      pixel_wr_en      <= 1'b0;
      pixel_wr_addr    <= '0;
      pixel_wr_data    <= '0;
      frame_valid      <= 1'b0;
      frame_error_tick <= 1'b0;
      error_code       <= ERR_NONE;
      busy             <= 1'b0;
    end else begin
      pixel_wr_en      <= 1'b0;
      frame_error_tick <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_done_tick && rx_data == SYNC_BYTE) begin
            byte_cnt <= '0;
            sum      <= '0;
            busy     <= 1'b1;
            state    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (rx_done_tick) begin
            pixel_wr_en   <= 1'b1;
            pixel_wr_addr <= byte_cnt;
            pixel_wr_data <= rx_data;
            sum           <= sum_next;
            if (byte_cnt == LAST_ADDR) begin
              state <= CHECKSUM;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (timeout) begin
            frame_error_tick <= 1'b1;
            error_code       <= ERR_TIMEOUT;
            busy             <= 1'b0;
            state            <= HUNT;
          end
        end
        CHECKSUM: begin
          if (rx_done_tick) begin
            busy <= 1'b0;
            if (sum_next == '0) begin
              frame_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              frame_error_tick <= 1'b1;
              error_code       <= ERR_CHECKSUM;
              state            <= HUNT;
            end
          end else if (timeout) begin
            frame_error_tick <= 1'b1;
            error_code       <= ERR_TIMEOUT;
            busy             <= 1'b0;
            state            <= HUNT;
          end
        end
        HOLD: begin
          // A byte here is always dropped, even when the ack lands in the same cycle.
          if (rx_done_tick) begin
            frame_error_tick <= 1'b1;
            error_code       <= ERR_OVERRUN;
          end
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Directed bench for uart_rx_frame_assembler with a 4-byte frame and a 100-cycle timeout.
module tb_uart_rx_frame_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       pixel_wr_en;
  logic [9:0] pixel_wr_addr;
  logic [7:0] pixel_wr_data;
  logic       frame_valid;
  logic       frame_ack;
  logic       frame_error_tick;
  logic [1:0] error_code;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;
  int wr_count = 0;
  int err_ticks = 0;

  uart_rx_frame_assembler #(
    .NUMBER_OF_DATA_BITS(8),
    .FRAME_LENGTH       (4),
    .ADDR_WIDTH         (10),
    .SYNC_BYTE          (8'hA5),
    .TIMEOUT_CYCLES     (100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_done_tick    (rx_done_tick),
    .pixel_wr_en     (pixel_wr_en),
    .pixel_wr_addr   (pixel_wr_addr),
    .pixel_wr_data   (pixel_wr_data),
    .frame_valid     (frame_valid),
    .frame_ack       (frame_ack),
    .frame_error_tick(frame_error_tick),
    .error_code      (error_code),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_wr_en === 1'b1) wr_count++;
    if (frame_error_tick === 1'b1) err_ticks++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    @(posedge clk); #1;
    rx_data      = b;
    rx_done_tick = 1'b1;
    frame_ack    = ack;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    frame_ack    = 1'b0;
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  // Sync, four payload bytes (first byte in the top of pl), then checksum byte cs.
  task automatic send_frame(input logic [31:0] pl, input logic [7:0] cs);
    logic [7:0] b;
    send_byte(8'hA5, 1'b0);
    chk("busy_after_sync", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      b = pl[31-8*i -: 8];
      send_byte(b, 1'b0);
      chk("wr_en", {31'd0, pixel_wr_en}, 32'd1);
      chk("wr_addr", {22'd0, pixel_wr_addr}, i);
      chk("wr_data", {24'd0, pixel_wr_data}, {24'd0, b});
    end
    send_byte(cs, 1'b0);
  endtask

  initial begin
    int w0;
    int e0;
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    frame_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, pixel_wr_en}, 0);
    chk("rst_valid", {31'd0, frame_valid}, 0);
    chk("rst_err_tick", {31'd0, frame_error_tick}, 0);
    chk("rst_err_code", {30'd0, error_code}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_addr", {22'd0, pixel_wr_addr}, 0);
    reset = 1'b1;

    // Good frame: 10+20+30+40 = A0, checksum 60.
    send_frame(32'h10203040, 8'h60);
    chk("t1_valid", {31'd0, frame_valid}, 1);
    chk("t1_err_code", {30'd0, error_code}, 0);
    chk("t1_busy", {31'd0, busy}, 0);
    pulse_ack();
    chk("t1_valid_after_ack", {31'd0, frame_valid}, 0);

    // Bad checksum, then a good frame 01..04 (sum 0A, checksum F6).
    send_frame(32'h10203040, 8'h61);
    chk("t2_err_tick", {31'd0, frame_error_tick}, 1);
    chk("t2_err_code", {30'd0, error_code}, 1);
    chk("t2_valid", {31'd0, frame_valid}, 0);
    chk("t2_busy", {31'd0, busy}, 0);
    send_frame(32'h01020304, 8'hF6);
    chk("t2_recover_valid", {31'd0, frame_valid}, 1);
    pulse_ack();

    // Junk before sync, and A5 inside the payload is data (sum 0B, checksum F5).
    w0 = wr_count;
    send_byte(8'h00, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("t3_no_write", w0 - wr_count, 0);
    chk("t3_busy_hunt", {31'd0, busy}, 0);
    send_frame(32'hA5112233, 8'hF5);
    chk("t3_valid", {31'd0, frame_valid}, 1);
    chk("t3_writes", wr_count - w0, 4);

    // Byte during HOLD is an overrun; then ack and byte together.
    send_byte(8'h55, 1'b0);
    chk("t4_err_tick", {31'd0, frame_error_tick}, 1);
    chk("t4_err_code", {30'd0, error_code}, 3);
    chk("t4_valid_held", {31'd0, frame_valid}, 1);
    send_byte(8'h77, 1'b1);
    chk("t4_ack_valid", {31'd0, frame_valid}, 0);
    chk("t4_ack_overrun", {31'd0, frame_error_tick}, 1);
    pulse_ack();
    chk("t4_ack_ignored", {31'd0, frame_valid}, 0);

    // Reset mid-frame, then a full frame from address 0.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_wr_en", {31'd0, pixel_wr_en}, 0);
    chk("t5_rst_err_code", {30'd0, error_code}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    send_frame(32'h10203040, 8'h60);
    chk("t5_valid", {31'd0, frame_valid}, 1);
    pulse_ack();

    // Stall after one payload byte.
    e0 = err_ticks;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
`ifdef FRAME_TIMEOUT_EN
    for (int i = 0; i < 150 && err_ticks == e0; i++) @(posedge clk);
    #1;
    chk("t6_timeout_tick", err_ticks - e0, 1);
    chk("t6_err_code", {30'd0, error_code}, 2);
    chk("t6_busy", {31'd0, busy}, 0);
`else
    repeat (150) @(posedge clk);
    #1;
    chk("t6_no_timeout", err_ticks - e0, 0);
    chk("t6_busy_waiting", {31'd0, busy}, 1);
    chk("t6_err_code", {30'd0, error_code}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
